// File: rtl/pixel_word_packer_if.sv
// Pixel/frame input bus and packed-word output bus of the pixel word packer.
interface pixel_word_packer_if #(
  parameter int PIX_W  = 12,
  parameter int WORD_W = 16,
  parameter int CNT_W  = 20
);
  logic [PIX_W-1:0]  iDATA;
  logic              iDVAL;
  logic              iFVAL;
  logic              iLVAL;
  logic              iSTART;
  logic              iEND;
  logic [PIX_W-1:0]  iTHRESH;
  logic [WORD_W-1:0] oDATA;
  logic              oDVAL;
  logic [CNT_W-1:0]  oWORD_CNT;
  logic [15:0]       oFRAME_CNT;
  logic              oFRAME_DONE;
  logic              oOVF;
  logic              oBUSY;

  // Pixel source side: drives video timing and control, observes packed words
  modport master (
    output iDATA, iDVAL, iFVAL, iLVAL, iSTART, iEND, iTHRESH,
    input  oDATA, oDVAL, oWORD_CNT, oFRAME_CNT, oFRAME_DONE, oOVF, oBUSY
  );

  // Packer side
  modport slave (
    input  iDATA, iDVAL, iFVAL, iLVAL, iSTART, iEND, iTHRESH,
    output oDATA, oDVAL, oWORD_CNT, oFRAME_CNT, oFRAME_DONE, oOVF, oBUSY
  );
endinterface

// File: rtl/pixel_word_packer.sv
// Packs BPP-bit pixel fields (thresholded for BPP=1, MSBs otherwise) into
// WORD_W-bit words, flushing partial words at line/frame end, with frame
// arming/stop control, per-frame word limit and frame counting.
module pixel_word_packer #(
  parameter int PIX_W     = 12,
  parameter int BPP       = 1,
  parameter int WORD_W    = 16,
  parameter int MAX_WORDS = 19200,
  parameter int CNT_W     = 20
) (
  input  logic              iCLK,
  input  logic              iRST,
  pixel_word_packer_if.slave bus
);
  localparam int PPW    = WORD_W / BPP;
  localparam int SLOT_W = $clog2(PPW + 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PPW - 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_WORDS);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE} state_t;

  state_t            state_reg, state_next;
  logic              stop_pending_reg, stop_pending_next;
  logic              fval_reg, lval_reg;
  logic [SLOT_W-1:0] slot_reg, slot_next;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic [WORD_W-1:0] data_reg, data_next;
  logic              dval_reg, dval_next;
  logic [CNT_W-1:0]  word_cnt_reg, word_cnt_next;
  logic [15:0]       frame_cnt_reg, frame_cnt_next;
  logic              done_reg, done_next;
  logic              ovf_reg, ovf_next;

  logic              fval_rise, fval_fall, lval_fall;
  logic              capture, accept, frame_start, emit;
  logic [SLOT_W-1:0] slot_base;
  logic [CNT_W-1:0]  cnt_base;
  logic [WORD_W-1:0] shift_base;
  logic [BPP-1:0]    pix_field;

  // Edges compare the live input against last cycle's sample
  assign fval_rise = bus.iFVAL & ~fval_reg;
  assign fval_fall = ~bus.iFVAL & fval_reg;
  assign lval_fall = ~bus.iLVAL & lval_reg;

  assign capture = (state_reg == CAPTURE);
  assign accept  = capture & bus.iDVAL & bus.iLVAL;

  // A new frame restarts the word count and packing, whether already
  // capturing or just leaving ARMED on this rise
  assign frame_start = fval_rise & (capture | ((state_reg == ARMED) & ~bus.iEND));
  assign slot_base   = frame_start ? '0 : slot_reg;
  assign cnt_base    = frame_start ? '0 : word_cnt_reg;
  assign shift_base  = (slot_base == '0) ? '0 : shift_reg;

  generate
    if (BPP == 1) begin : g_binarise
      assign pix_field = (bus.iDATA > bus.iTHRESH);
    end else begin : g_msbs
      logic unused_thresh;
      assign pix_field     = bus.iDATA[PIX_W-1 -: BPP];
      assign unused_thresh = ^{bus.iTHRESH, bus.iDATA};
    end
  endgenerate

  // FSM state register
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_reg        <= IDLE;
      stop_pending_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      stop_pending_reg <= stop_pending_next;
    end
  end

  // FSM next state: arm, start on frame rise, stop at frame end when requested
  always_comb begin
    state_next        = state_reg;
    stop_pending_next = stop_pending_reg;
    case (state_reg)
      IDLE:    if (bus.iSTART) state_next = ARMED;
      ARMED: begin
        if (bus.iEND)       state_next = IDLE;
        else if (fval_rise) state_next = CAPTURE;
      end
      CAPTURE: begin
        if (bus.iEND) stop_pending_next = 1'b1;
        if (fval_fall && (stop_pending_reg || bus.iEND)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (state_next == IDLE) stop_pending_next = 1'b0;
  end

  // Packing, word emission (full or flushed partial), limits and frame counting
  always_comb begin
    shift_next     = shift_base;
    slot_next      = slot_base;
    data_next      = data_reg;
    dval_next      = 1'b0;
    word_cnt_next  = cnt_base;
    frame_cnt_next = frame_cnt_reg;
    done_next      = 1'b0;
    ovf_next       = ovf_reg;
    emit           = 1'b0;
    if (accept) begin
      shift_next = shift_base | (WORD_W'(pix_field) << (slot_base * BPP));
      slot_next  = slot_base + SLOT_W'(1);
    end
    if (capture) begin
      if (accept && (slot_base == LAST_SLOT))
        emit = 1'b1;
      else if ((lval_fall || fval_fall) && (slot_next != '0))
        emit = 1'b1;
    end
    if (emit) begin
      slot_next = '0;
      if (cnt_base == CNT_LIMIT) begin
        ovf_next = 1'b1;
      end else begin
        data_next     = shift_next;
        dval_next     = 1'b1;
        word_cnt_next = cnt_base + CNT_W'(1);
      end
    end
    if (capture && fval_fall) begin
      done_next      = 1'b1;
      frame_cnt_next = frame_cnt_reg + 16'd1;
    end
  end

  // Datapath and output registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      fval_reg      <= 1'b0;
      lval_reg      <= 1'b0;
      slot_reg      <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      dval_reg      <= 1'b0;
      word_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
      done_reg      <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      fval_reg      <= bus.iFVAL;
      lval_reg      <= bus.iLVAL;
      slot_reg      <= slot_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      dval_reg      <= dval_next;
      word_cnt_reg  <= word_cnt_next;
      frame_cnt_reg <= frame_cnt_next;
      done_reg      <= done_next;
      ovf_reg       <= ovf_next;
    end
  end

  assign bus.oDATA       = data_reg;
  assign bus.oDVAL       = dval_reg;
  assign bus.oWORD_CNT   = word_cnt_reg;
  assign bus.oFRAME_CNT  = frame_cnt_reg;
  assign bus.oFRAME_DONE = done_reg;
  assign bus.oOVF        = ovf_reg;
  assign bus.oBUSY       = (state_reg != IDLE);
endmodule

// File: doc/pixel_word_packer.md
PIXEL_WORD_PACKER -- requirements
Module: pixel_word_packer

Interface
REQ-001 Parameters SHALL be: PIX_W, default 12, input pixel width; BPP, default 1, packed bits per pixel (legal: 1, 2, 4, 8); WORD_W, default 16, output word width (a multiple of BPP); MAX_WORDS, default 19200, word limit per frame; CNT_W, default 20, counter width.
REQ-002 iCLK  in  1  single clock; all logic on its rising edge.
REQ-003 iRST  in  1  reset, synchronous and active-high.
REQ-004 iDATA  in  PIX_W  pixel value; iDVAL  in  1  pixel valid.
REQ-005 iFVAL  in  1  frame valid; iLVAL  in  1  line valid.
REQ-006 iSTART  in  1  arm capture; iEND  in  1  request stop at end of frame.
REQ-007 iTHRESH  in  PIX_W  binarisation threshold, used only when BPP=1.
REQ-008 oDATA  out  WORD_W  packed word; oDVAL  out  1  one-cycle write strobe.
REQ-009 oWORD_CNT  out  CNT_W  words emitted in the current frame; oFRAME_CNT  out  16  frames completed.
REQ-010 oFRAME_DONE  out  1  one-cycle end-of-frame pulse; oOVF  out  1  sticky word-limit overflow flag.
REQ-011 oBUSY  out  1  high while the state is ARMED or CAPTURE.

Function
REQ-012 The block SHALL register iFVAL and iLVAL each cycle, and edges SHALL be detected as current sample versus previous sample.
REQ-013 The FSM SHALL have the states IDLE, ARMED and CAPTURE.
- IDLE -> ARMED when iSTART=1.
- ARMED -> CAPTURE on the cycle an iFVAL rising edge is seen.
- CAPTURE -> IDLE on an iFVAL falling edge if a stop is pending.
- Otherwise CAPTURE SHALL remain, giving continuous frames.
REQ-014 iEND=1 in ARMED SHALL return the FSM to IDLE; iEND=1 in CAPTURE SHALL set stop-pending, which clears on entry to IDLE.
REQ-015 A pixel SHALL be accepted when the state is CAPTURE, iDVAL=1 and iLVAL=1; pixels arriving in ARMED mid-frame SHALL be ignored.
REQ-016 The packed value SHALL be:
- BPP=1: 1 when iDATA > iTHRESH, else 0 (strictly greater than).
- BPP>1: iDATA[PIX_W-1 : PIX_W-BPP].
REQ-017 Packing order SHALL be: the first accepted pixel of a word in bits [BPP-1:0], and each later pixel in the next higher BPP-bit field.
REQ-018 Once WORD_W/BPP pixels are accepted, oDATA SHALL present the word and oDVAL SHALL pulse high for exactly 1 cycle, on the cycle after the last pixel is accepted; the slot counter SHALL clear.
REQ-019 On an iLVAL falling edge in CAPTURE with 0 < slot count < WORD_W/BPP, the partial word SHALL be emitted the next cycle, with unused high fields zero-padded.
REQ-020 If a word completes on the same cycle iLVAL falls, exactly one word SHALL be emitted, with no extra pad word.
REQ-021 Every line SHALL start packing at slot 0.
REQ-022 On an iFVAL rising edge while in CAPTURE or entering CAPTURE, oWORD_CNT and the slot counter SHALL clear.
REQ-023 oWORD_CNT SHALL increment on each oDVAL.
REQ-024 When oWORD_CNT = MAX_WORDS, further words SHALL be suppressed (no oDVAL, counter held) and oOVF SHALL set; oOVF SHALL clear only on iRST.
REQ-025 On an iFVAL falling edge in CAPTURE, oFRAME_DONE SHALL pulse for 1 cycle and oFRAME_CNT SHALL increment, wrapping from 16'hFFFF to 0.
REQ-026 If iFVAL falls with a partial word outstanding and iLVAL still high, the flush SHALL occur before oFRAME_DONE (flush cycle N+1, done cycle N+1 as well is permitted); the partial word SHALL never be lost.
REQ-027 oDATA SHALL hold its last value between strobes.

Reset
REQ-028 iRST=1 SHALL force state IDLE and clear stop-pending, the slot counter and the shift register.
REQ-029 iRST=1 SHALL zero all outputs: oDATA, oDVAL, oWORD_CNT, oFRAME_CNT, oFRAME_DONE, oOVF and oBUSY.
REQ-030 iRST asserted mid-word SHALL discard the partial word with no oDVAL.
REQ-031 iRST SHALL take priority over every other input on the same cycle.

Verification
REQ-032 The bench SHALL cover: BPP=1, iTHRESH=100, 16 pixels of alternating 200 and 50 on one line -> one oDVAL with oDATA=16'h5555, one cycle after the 16th pixel.
REQ-033 The bench SHALL cover: BPP=1, a 20-pixel line of value 4095 -> words 16'hFFFF then 16'h000F (pad), the second one cycle after the iLVAL fall; oWORD_CNT=2.
REQ-034 The bench SHALL cover: BPP=4, WORD_W=16, pixels 12'h1xx, 12'h2xx, 12'h3xx, 12'h4xx -> oDATA=16'h4321.
REQ-035 The bench SHALL cover: MAX_WORDS=2 with a 48-pixel line (BPP=1) -> exactly 2 oDVAL pulses, oOVF=1 and held across the next frame.
REQ-036 The bench SHALL cover: iSTART pulsed mid-frame -> no oDVAL until the next iFVAL rise; iEND during frame 3 -> oFRAME_DONE for frame 3, then IDLE, oBUSY=0, oFRAME_CNT=3.
REQ-037 The bench SHALL cover: iRST pulsed after 7 of 16 pixels -> no oDVAL, all outputs 0, and the next armed frame's first word packs from slot 0.
